// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the RV64 5-stage pipeline control logic:
//   - hazard sequencer state encoding (RUN / MEM_WAIT)
//   - instruction field bit positions (opcode, rd, rs1, rs2)
//   - bundled stall/flush/redirect control word and its canonical values
//   - load-detect helper on the ID memory-read control field
// -----------------------------------------------------------------------------
package rv_pipe_pkg;

  // Sequencer state encoding
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Instruction field positions
  localparam int OPC_MSB = 6;
  localparam int OPC_LSB = 0;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;
  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  // One bit per stage-register control, MSB first
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic flush_wb;
    logic pc_redirect;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE     = hz_ctrl_t'(8'b0000_0000);
  // Whole pipe frozen; a bubble is pushed into WB so the stalled MEM op retires once
  localparam hz_ctrl_t CTRL_FREEZE   = hz_ctrl_t'(8'b1111_0010);
  // Redirect: squash the two younger instructions fetched down the wrong path
  localparam hz_ctrl_t CTRL_REDIRECT = hz_ctrl_t'(8'b0000_1101);
  // Load-use: hold IF/ID one cycle and inject a bubble into EX
  localparam hz_ctrl_t CTRL_LU_STALL = hz_ctrl_t'(8'b1100_0100);

  // Any non-zero memory-read control marks the instruction as a load
  function automatic logic is_load(input logic [2:0] dm_rd_ctrl);
    return (dm_rd_ctrl != 3'b000);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
//   master drives : instr_IF, rd_ID, rf_wr_en_ID, dm_rd_ctrl_ID,
//                   branch_taken_EX, target_EX, dmem_busy
//   slave drives  : stall_if/id/ex/mem, flush_id/ex/wb, pc_redirect, pc_target,
//                   mem_timeout_err, stall_cnt, redirect_cnt
// CNT_W must match the CNT_W of the connected pipeline_hazard_ctrl.
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_IF;
  logic [4:0]       rd_ID;
  logic             rf_wr_en_ID;
  logic [2:0]       dm_rd_ctrl_ID;
  logic             branch_taken_EX;
  logic [63:0]      target_EX;
  logic             dmem_busy;

  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_wb;
  logic             pc_redirect;
  logic [63:0]      pc_target;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output instr_IF, rd_ID, rf_wr_en_ID, dm_rd_ctrl_ID,
           branch_taken_EX, target_EX, dmem_busy,
    input  stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_wb, pc_redirect, pc_target,
           mem_timeout_err, stall_cnt, redirect_cnt
  );

  modport slave (
    input  instr_IF, rd_ID, rf_wr_en_ID, dm_rd_ctrl_ID,
           branch_taken_EX, target_EX, dmem_busy,
    output stall_if, stall_id, stall_ex, stall_mem,
           flush_id, flush_ex, flush_wb, pc_redirect, pc_target,
           mem_timeout_err, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_lu_detect.sv
// -----------------------------------------------------------------------------
// hazard_lu_detect
// Combinational load-use detector: flags when the load sitting in the ID stage
// register writes a register read by the instruction in IF.
//   instr_i          in  32  IF instruction (rs1/rs2 fields used)
//   rd_id_i          in  5   ID destination register
//   rf_wr_en_id_i    in  1   ID writes rd
//   dm_rd_ctrl_id_i  in  3   ID memory-read control
//   lu_hazard_o      out 1   load-use hazard
// rs1 and rs2 are compared regardless of instruction format; a spurious match
// only costs one bubble, which is cheaper than decoding the format here.
// -----------------------------------------------------------------------------
module hazard_lu_detect
  import rv_pipe_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [4:0]  rd_id_i,
  input  logic        rf_wr_en_id_i,
  input  logic [2:0]  dm_rd_ctrl_id_i,
  output logic        lu_hazard_o
);

  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       unused_instr_s;

  assign rs1_s = instr_i[RS1_MSB:RS1_LSB];
  assign rs2_s = instr_i[RS2_MSB:RS2_LSB];

  // Bits outside the rs fields play no part in the decision
  assign unused_instr_s = ^{instr_i[31:25], instr_i[14:0]};

  // x0 is hard-wired zero, so a load "to x0" never creates a dependency
  assign lu_hazard_o = is_load(dm_rd_ctrl_id_i) & rf_wr_en_id_i &
                       (rd_id_i != 5'd0) &
                       ((rd_id_i == rs1_s) | (rd_id_i == rs2_s));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RV64 pipeline.
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   hz     slave side of pipeline_hazard_ctrl_if (hazard inputs, stage controls,
//          PC redirect, watchdog flag, performance counters)
// Controls are combinational from the registered state and current inputs.
// While dmem_busy is high the whole pipe freezes; a branch resolved in the
// first busy cycle is parked and issued on the cycle memory completes.
// A watchdog flags mem_timeout_err (sticky until reset) after MEM_TIMEOUT
// consecutive busy cycles.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
)(
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int             WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  logic [0:0]       state_q,        state_d;
  logic             redir_pend_q,   redir_pend_d;
  logic [63:0]      pend_target_q,  pend_target_d;
  logic [WC_W-1:0]  wait_cnt_q,     wait_cnt_d;
  logic             timeout_err_q,  timeout_err_d;
  logic [CNT_W-1:0] stall_cnt_q,    stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  logic             lu_hazard_s;
  hz_ctrl_t         ctrl_s;
  hz_ctrl_t         ctrl_out_s;
  logic [63:0]      target_s;

  hazard_lu_detect u_lu_detect (
    .instr_i         (hz.instr_IF),
    .rd_id_i         (hz.rd_ID),
    .rf_wr_en_id_i   (hz.rf_wr_en_ID),
    .dm_rd_ctrl_id_i (hz.dm_rd_ctrl_ID),
    .lu_hazard_o     (lu_hazard_s)
  );

  // Sequencer next-state, pending-redirect latch, watchdog and control word
  always_comb begin
    ctrl_s        = CTRL_IDLE;
    target_s      = 64'd0;
    state_d       = state_q;
    redir_pend_d  = redir_pend_q;
    pend_target_d = pend_target_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_RUN: begin
        if (hz.dmem_busy) begin
          ctrl_s     = CTRL_FREEZE;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_ONE;
          // The branch cannot redirect while IF is frozen; park it
          if (hz.branch_taken_EX) begin
            redir_pend_d  = 1'b1;
            pend_target_d = hz.target_EX;
          end else begin
            redir_pend_d  = redir_pend_q;
          end
        end else if (hz.branch_taken_EX) begin
          // Redirect squashes the IF instruction, so a load-use stall is moot
          ctrl_s   = CTRL_REDIRECT;
          target_s = hz.target_EX;
        end else if (lu_hazard_s) begin
          ctrl_s = CTRL_LU_STALL;
        end else begin
          ctrl_s = CTRL_IDLE;
        end
      end

      ST_MEM_WAIT: begin
        if (hz.dmem_busy) begin
          // EX is frozen, so branch_taken_EX still reflects the parked branch
          ctrl_s = CTRL_FREEZE;
          if (wait_cnt_q < WC_MAX) begin
            wait_cnt_d = wait_cnt_q + WC_ONE;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (redir_pend_q) begin
            ctrl_s       = CTRL_REDIRECT;
            target_s     = pend_target_q;
            redir_pend_d = 1'b0;
          end else if (hz.branch_taken_EX) begin
            ctrl_s   = CTRL_REDIRECT;
            target_s = hz.target_EX;
          end else if (lu_hazard_s) begin
            ctrl_s = CTRL_LU_STALL;
          end else begin
            ctrl_s = CTRL_IDLE;
          end
        end
      end

      default: begin
        state_d      = ST_RUN;
        redir_pend_d = 1'b0;
        wait_cnt_d   = '0;
      end
    endcase

    // Covers MEM_TIMEOUT=1, where the first busy cycle already expires
    if (hz.dmem_busy && (wait_cnt_d == WC_MAX)) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_d;
    end
  end

  // Performance counters, wrapping on overflow
  always_comb begin
    stall_cnt_d    = stall_cnt_q    + CNT_W'(ctrl_s.stall_if);
    redirect_cnt_d = redirect_cnt_q + CNT_W'(ctrl_s.pc_redirect);
  end

  // State, pending redirect, watchdog and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      redir_pend_q   <= 1'b0;
      pend_target_q  <= 64'd0;
      wait_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      redir_pend_q   <= redir_pend_d;
      pend_target_q  <= pend_target_d;
      wait_cnt_q     <= wait_cnt_d;
      timeout_err_q  <= timeout_err_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Controls are forced quiet while reset is held, whatever the inputs do
  assign ctrl_out_s = reset ? ctrl_s : CTRL_IDLE;

  assign hz.stall_if        = ctrl_out_s.stall_if;
  assign hz.stall_id        = ctrl_out_s.stall_id;
  assign hz.stall_ex        = ctrl_out_s.stall_ex;
  assign hz.stall_mem       = ctrl_out_s.stall_mem;
  assign hz.flush_id        = ctrl_out_s.flush_id;
  assign hz.flush_ex        = ctrl_out_s.flush_ex;
  assign hz.flush_wb        = ctrl_out_s.flush_wb;
  assign hz.pc_redirect     = ctrl_out_s.pc_redirect;
  assign hz.pc_target       = reset ? target_s : 64'd0;
  assign hz.mem_timeout_err = timeout_err_q;
  assign hz.stall_cnt       = stall_cnt_q;
  assign hz.redirect_cnt    = redirect_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that tracks "in a memory wait", "redirect parked" and the
// length of the current busy run.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 32;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic reset;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit               m_wait;
  bit               m_pend;
  bit               m_err;
  logic [63:0]      m_tgt;
  int               m_run;
  logic [CNT_W-1:0] m_scnt;
  logic [CNT_W-1:0] m_rcnt;
  logic [7:0]       e_ctrl;
  logic [63:0]      e_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs_ctrl();
    return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
            bus.flush_id, bus.flush_ex, bus.flush_wb, bus.pc_redirect};
  endfunction

  task automatic model_reset();
    m_wait = 1'b0; m_pend = 1'b0; m_err = 1'b0; m_tgt = 64'd0;
    m_run  = 0;    m_scnt = '0;   m_rcnt = '0;
  endtask

  // Expected controls for the current inputs (bit order as obs_ctrl)
  task automatic model_eval();
    logic [31:0] ins;
    logic [4:0]  rd;
    bit          haz;
    ins = bus.instr_IF;
    rd  = bus.rd_ID;
    haz = (bus.dm_rd_ctrl_ID != 3'd0) && bus.rf_wr_en_ID && (rd != 5'd0) &&
          (rd == ins[19:15] || rd == ins[24:20]);
    e_pc = 64'd0;
    if (bus.dmem_busy)             e_ctrl = 8'b1111_0010;
    else if (m_pend)               begin e_ctrl = 8'b0000_1101; e_pc = m_tgt; end
    else if (bus.branch_taken_EX)  begin e_ctrl = 8'b0000_1101; e_pc = bus.target_EX; end
    else if (haz)                  e_ctrl = 8'b1100_0100;
    else                           e_ctrl = 8'b0000_0000;
  endtask

  // Advance the model across one rising edge
  task automatic model_commit();
    if (bus.dmem_busy) begin
      if (!m_wait && bus.branch_taken_EX) begin
        m_pend = 1'b1;
        m_tgt  = bus.target_EX;
      end
      m_run++;
      if (m_run >= TMO) m_err = 1'b1;
      m_wait = 1'b1;
    end else begin
      m_run  = 0;
      m_wait = 1'b0;
      m_pend = 1'b0;
    end
    m_scnt += CNT_W'(e_ctrl[7]);
    m_rcnt += CNT_W'(e_ctrl[0]);
  endtask

  task automatic cycle(input logic [31:0] ins, input logic [4:0] rd, input logic wr,
                       input logic [2:0] dm, input logic br, input logic [63:0] tgt,
                       input logic busy);
    @(negedge clk);
    bus.instr_IF = ins; bus.rd_ID = rd; bus.rf_wr_en_ID = wr; bus.dm_rd_ctrl_ID = dm;
    bus.branch_taken_EX = br; bus.target_EX = tgt; bus.dmem_busy = busy;
    #1;
    model_eval();
    check("ctrl", {56'd0, obs_ctrl()}, {56'd0, e_ctrl});
    check("pc_target", bus.pc_target, e_pc);
    @(posedge clk);
    #1;
    model_commit();
    check("stall_cnt", {32'd0, bus.stall_cnt}, {32'd0, m_scnt});
    check("redirect_cnt", {32'd0, bus.redirect_cnt}, {32'd0, m_rcnt});
    check("timeout_err", {63'd0, bus.mem_timeout_err}, {63'd0, m_err});
  endtask

  // Async reset with hostile inputs applied, checked before any clock edge
  task automatic do_reset();
    @(negedge clk);
    bus.instr_IF = 32'h00128333; bus.rd_ID = 5'd5; bus.rf_wr_en_ID = 1'b1;
    bus.dm_rd_ctrl_ID = 3'b011; bus.branch_taken_EX = 1'b1;
    bus.target_EX = 64'hDEAD_BEEF; bus.dmem_busy = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("rst_ctrl", {56'd0, obs_ctrl()}, 64'd0);
    check("rst_pc_target", bus.pc_target, 64'd0);
    check("rst_counters", {bus.stall_cnt, bus.redirect_cnt}, 64'd0);
    check("rst_timeout_err", {63'd0, bus.mem_timeout_err}, 64'd0);
    @(negedge clk);
    bus.branch_taken_EX = 1'b0; bus.dmem_busy = 1'b0; bus.dm_rd_ctrl_ID = 3'd0;
    reset = 1'b1;
  endtask

  localparam logic [31:0] ADD_X6_X5_X1 = 32'h00128333;

  initial begin
    reset = 1'b0;
    bus.instr_IF = 32'd0; bus.rd_ID = 5'd0; bus.rf_wr_en_ID = 1'b0; bus.dm_rd_ctrl_ID = 3'd0;
    bus.branch_taken_EX = 1'b0; bus.target_EX = 64'd0; bus.dmem_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // 1. load-use stall
    cycle(ADD_X6_X5_X1, 5'd5, 1'b1, 3'b011, 1'b0, 64'd0, 1'b0);
    check("t1_stall_cnt", {32'd0, bus.stall_cnt}, 64'd1);
    // 2. x0 destination / non-load: no hazard
    cycle(32'h00100333, 5'd0, 1'b1, 3'b011, 1'b0, 64'd0, 1'b0);
    cycle(ADD_X6_X5_X1, 5'd5, 1'b1, 3'b000, 1'b0, 64'd0, 1'b0);
    // 3. redirect, then redirect with concurrent hazard
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b1, 64'h8000_0040, 1'b0);
    check("t3_redirect_cnt", {32'd0, bus.redirect_cnt}, 64'd1);
    cycle(ADD_X6_X5_X1, 5'd5, 1'b1, 3'b011, 1'b1, 64'h8000_0040, 1'b0);

    // 4. memory wait with a parked branch; later branch in the wait is ignored
    do_reset();
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b1, 64'h100, 1'b1);
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b1, 64'h200, 1'b1);
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b1, 64'h300, 1'b1);
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'h0, 1'b0);
    check("t4_stall_cnt", {32'd0, bus.stall_cnt}, 64'd3);
    check("t4_redirect_cnt", {32'd0, bus.redirect_cnt}, 64'd1);

    // 5. watchdog: trips on the 8th busy cycle and stays set
    do_reset();
    repeat (TMO - 1) cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1);
    check("t5_not_yet", {63'd0, bus.mem_timeout_err}, 64'd0);
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1);
    check("t5_tripped", {63'd0, bus.mem_timeout_err}, 64'd1);
    repeat (3) cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
    check("t5_sticky", {63'd0, bus.mem_timeout_err}, 64'd1);

    // 6. reset in the middle of a wait with a parked redirect
    do_reset();
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b1, 64'h440, 1'b1);
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b1);
    do_reset();
    cycle(32'd0, 5'd0, 1'b0, 3'd0, 1'b0, 64'd0, 1'b0);
    check("t6_no_redirect", {32'd0, bus.redirect_cnt}, 64'd0);

    // Randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      logic [63:0] tgt;
      ins = $urandom();
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      tgt = {$urandom(), $urandom()};
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(ins,
            5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
            1'($urandom_range(0, 4) == 0),
            tgt,
            1'($urandom_range(0, 9) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
